// File: rtl/tlb_lookup_stage_p_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tlb_lookup_stage_p_if                                      |
// | Purpose  : Pipeline, bypass and refill-walker signals of the          |
// |            TLB-lookup stage. The slave modport is the stage itself;    |
// |            the master modport is its surroundings (EX, hazard control, |
// |            bypass network, page-table walker, CACHE).                  |
// | Revision : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
interface tlb_lookup_stage_p_if #(
  parameter int DATA_W     = 16,
  parameter int PAGE_BITS  = 8,
  parameter int REG_ADDR_W = 3,
  parameter int ROB_W      = 3,
  parameter int N_BYP      = 2
);
  // Upstream op and control
  logic                          enable_tlblookup;
  logic                          valid_in;
  logic [DATA_W-1:0]             alu_result;
  logic [DATA_W-1:0]             dataReg;
  logic [1:0]                    ldSt_enable;
  logic [REG_ADDR_W-1:0]         destReg_addr_input;
  logic                          we_input;
  logic [1:0]                    bp_input;
  logic [ROB_W-1:0]              tail_rob_input;
  logic                          vm_enable;
  logic                          tlb_flush;
  // Store-data bypass sources
  logic [N_BYP-1:0]              byp_valid;
  logic [N_BYP*REG_ADDR_W-1:0]   byp_addr;
  logic [N_BYP*DATA_W-1:0]       byp_data;
  // Page-table walker
  logic                          refill_ack;
  logic [DATA_W-PAGE_BITS-1:0]   refill_ppn;
  logic                          refill_req;
  logic [DATA_W-PAGE_BITS-1:0]   refill_vpn;
  // Toward CACHE
  logic [DATA_W-1:0]             tlblookup_result;
  logic [REG_ADDR_W-1:0]         destReg_addr_output;
  logic                          we_output;
  logic [1:0]                    bp_output;
  logic [1:0]                    ldSt_enable_output;
  logic [ROB_W-1:0]              tail_rob_output;
  logic [DATA_W-1:0]             dataReg_output;
  logic                          valid_out;
  logic                          stall_out;

  modport slave (
    input  enable_tlblookup, valid_in, alu_result, dataReg, ldSt_enable,
           destReg_addr_input, we_input, bp_input, tail_rob_input,
           vm_enable, tlb_flush, byp_valid, byp_addr, byp_data,
           refill_ack, refill_ppn,
    output refill_req, refill_vpn, tlblookup_result, destReg_addr_output,
           we_output, bp_output, ldSt_enable_output, tail_rob_output,
           dataReg_output, valid_out, stall_out
  );

  modport master (
    output enable_tlblookup, valid_in, alu_result, dataReg, ldSt_enable,
           destReg_addr_input, we_input, bp_input, tail_rob_input,
           vm_enable, tlb_flush, byp_valid, byp_addr, byp_data,
           refill_ack, refill_ppn,
    input  refill_req, refill_vpn, tlblookup_result, destReg_addr_output,
           we_output, bp_output, ldSt_enable_output, tail_rob_output,
           dataReg_output, valid_out, stall_out
  );
endinterface
`default_nettype wire

// File: rtl/tlb_lookup_stage_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tlb_lookup_stage_p                                         |
// | Purpose  : EX->CACHE stage register with fully-associative TLB,       |
// |            miss stall + walker refill handshake, and store-data       |
// |            bypass that is refreshed while the stage is held.          |
// | Revision : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tlb_lookup_stage_p #(
  parameter int DATA_W      = 16,
  parameter int PAGE_BITS   = 8,
  parameter int TLB_ENTRIES = 4,
  parameter int REG_ADDR_W  = 3,
  parameter int ROB_W       = 3,
  parameter int N_BYP       = 2
) (
  input wire                  clk,
  input wire                  reset,
  tlb_lookup_stage_p_if.slave bus
);
  localparam int c_vpn_w = DATA_W - PAGE_BITS;
  localparam int c_idx_w = $clog2(TLB_ENTRIES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  // Held op
  logic                  r_valid;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_ldst;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_we;
  logic [1:0]            r_bp;
  logic [ROB_W-1:0]      r_rob;

  // TLB storage; only the valid bits need a reset value
  logic [TLB_ENTRIES-1:0] r_tlb_valid;
  logic [c_vpn_w-1:0]     r_tlb_vpn [TLB_ENTRIES];
  logic [c_vpn_w-1:0]     r_tlb_ppn [TLB_ENTRIES];
  logic [c_idx_w-1:0]     r_rr_ptr;

  logic                   w_xlate, w_hit, w_miss, w_stall, w_capture, w_refill_fire;
  logic [c_vpn_w-1:0]     w_held_vpn, w_hit_ppn;
  logic                   w_byp_hit;
  logic [DATA_W-1:0]      w_byp_data;
  logic [TLB_ENTRIES-1:0] w_tlb_valid_next;

  assign w_held_vpn    = r_alu[DATA_W-1:PAGE_BITS];
  assign w_xlate       = r_valid && (r_ldst != 2'b00) && bus.vm_enable;
  assign w_miss        = w_xlate && !w_hit;
  assign w_stall       = w_miss || (r_state != IDLE);
  assign w_capture     = bus.enable_tlblookup && !w_stall;
  assign w_refill_fire = (r_state == WAIT) && bus.refill_ack;

  // Associative lookup; scanning downward lets the lowest-index hit win
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ppn = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (r_tlb_valid[i] && (r_tlb_vpn[i] == w_held_vpn)) begin
        w_hit     = 1'b1;
        w_hit_ppn = r_tlb_ppn[i];
      end
    end
  end

  // Store bypass select; slot 0 is the youngest source and wins
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = r_data;
    for (int i = N_BYP - 1; i >= 0; i--) begin
      if (r_valid && (r_ldst == 2'b01) && bus.byp_valid[i] &&
          (bus.byp_addr[i*REG_ADDR_W +: REG_ADDR_W] == r_dest)) begin
        w_byp_hit  = 1'b1;
        w_byp_data = bus.byp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage register: capture when advancing, otherwise hold and keep bypassed store data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_data  <= '0;
      r_ldst  <= '0;
      r_dest  <= '0;
      r_we    <= 1'b0;
      r_bp    <= '0;
      r_rob   <= '0;
    end else if (w_capture) begin
      r_valid <= bus.valid_in;
      r_alu   <= bus.alu_result;
      r_data  <= bus.dataReg;
      r_ldst  <= bus.ldSt_enable;
      r_dest  <= bus.destReg_addr_input;
      r_we    <= bus.we_input;
      r_bp    <= bus.bp_input;
      r_rob   <= bus.tail_rob_input;
    end else if (w_byp_hit) begin
      r_data  <= w_byp_data;
    end
  end

  // Flush clears first so a refill landing on the same edge survives
  always_comb begin
    w_tlb_valid_next = bus.tlb_flush ? '0 : r_tlb_valid;
    if (w_refill_fire) begin
      w_tlb_valid_next[r_rr_ptr] = 1'b1;
    end
  end

  // TLB valid bits and round-robin victim pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tlb_valid <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_tlb_valid <= w_tlb_valid_next;
      if (w_refill_fire) begin
        r_rr_ptr <= r_rr_ptr + c_idx_w'(1);
      end
    end
  end

  // TLB tag/data write on refill
  always_ff @(posedge clk) begin
    if (w_refill_fire) begin
      r_tlb_vpn[r_rr_ptr] <= w_held_vpn;
      r_tlb_ppn[r_rr_ptr] <= bus.refill_ppn;
    end
  end

  // Refill FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Refill FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_state_next = WAIT;
      WAIT:    if (bus.refill_ack) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.refill_req          = (r_state == WAIT);
  assign bus.refill_vpn          = (r_state == WAIT) ? w_held_vpn : '0;
  assign bus.tlblookup_result    = (w_xlate && w_hit) ? {w_hit_ppn, r_alu[PAGE_BITS-1:0]} : r_alu;
  assign bus.destReg_addr_output = r_dest;
  assign bus.we_output           = r_we;
  assign bus.bp_output           = r_bp;
  assign bus.ldSt_enable_output  = r_ldst;
  assign bus.tail_rob_output     = r_rob;
  assign bus.dataReg_output      = w_byp_data;
  assign bus.valid_out           = r_valid && !w_stall;
  assign bus.stall_out           = w_stall;
endmodule
`default_nettype wire

// File: tb/tb_tlb_lookup_stage_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tlb_lookup_stage_p                                      |
// | Purpose  : Randomised scoreboard bench for tlb_lookup_stage_p. A      |
// |            page-table function plus a small replacement model predict |
// |            translations, refills and bypassed store data.             |
// | Revision : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_tlb_lookup_stage_p;
  localparam int DATA_W      = 16;
  localparam int PAGE_BITS   = 8;
  localparam int TLB_ENTRIES = 4;
  localparam int REG_ADDR_W  = 3;
  localparam int ROB_W       = 3;
  localparam int N_BYP       = 2;
  localparam int VPN_W       = DATA_W - PAGE_BITS;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     data;
    logic [1:0]            ldst;
    logic [REG_ADDR_W-1:0] dest;
    logic                  we;
    logic [1:0]            bp;
    logic [ROB_W-1:0]      rob;
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [1:0]            ldst;
    logic [REG_ADDR_W-1:0] dest;
    logic                  we;
    logic [1:0]            bp;
    logic [ROB_W-1:0]      rob;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t             sb_q[$];
  logic [VPN_W-1:0] refill_q[$];

  // Reference TLB contents and victim order
  logic             mv   [TLB_ENTRIES];
  logic [VPN_W-1:0] mvpn [TLB_ENTRIES];
  int               mrr;
  logic [VPN_W-1:0] vpn_pool [6];

  op_t              pres, held;
  logic             held_xlate, cap_now, in_ep, drain;
  logic [VPN_W-1:0] pend_vpn;
  int               wait_cnt, stall_run;

  always #5 clk = ~clk;

  tlb_lookup_stage_p_if #(
    .DATA_W(DATA_W), .PAGE_BITS(PAGE_BITS), .REG_ADDR_W(REG_ADDR_W),
    .ROB_W(ROB_W), .N_BYP(N_BYP)
  ) bus ();

  tlb_lookup_stage_p #(
    .DATA_W(DATA_W), .PAGE_BITS(PAGE_BITS), .TLB_ENTRIES(TLB_ENTRIES),
    .REG_ADDR_W(REG_ADDR_W), .ROB_W(ROB_W), .N_BYP(N_BYP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // The walker's view of memory: a fixed VPN->PPN mapping
  function automatic logic [VPN_W-1:0] page_table(input logic [VPN_W-1:0] v);
    return VPN_W'(int'(v) * 37 + 11);
  endfunction

  function automatic logic model_hit(input logic [VPN_W-1:0] v);
    for (int j = 0; j < TLB_ENTRIES; j++) if (mv[j] && mvpn[j] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < TLB_ENTRIES; j++) mv[j] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a new op (or a bubble while draining)
  task automatic make_op();
    pres.valid = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
    pres.alu   = {vpn_pool[$urandom_range(0, 5)], PAGE_BITS'($urandom)};
    pres.data  = DATA_W'($urandom);
    pres.ldst  = 2'($urandom_range(0, 2));
    pres.dest  = REG_ADDR_W'($urandom);
    pres.we    = 1'($urandom);
    pres.bp    = 2'($urandom);
    pres.rob   = ROB_W'($urandom);
    bus.valid_in           = pres.valid;
    bus.alu_result         = pres.alu;
    bus.dataReg            = pres.data;
    bus.ldSt_enable        = pres.ldst;
    bus.destReg_addr_input = pres.dest;
    bus.we_input           = pres.we;
    bus.bp_input           = pres.bp;
    bus.tail_rob_input     = pres.rob;
  endtask

  // The presented op has just been captured: drive its bypass sources and predict its result
  task automatic accept_held();
    logic [N_BYP-1:0]            bv;
    logic [N_BYP*REG_ADDR_W-1:0] ba;
    logic [N_BYP*DATA_W-1:0]     bd;
    logic                        found;
    logic [VPN_W-1:0]            vpn;
    exp_t                        e;
    held       = pres;
    held_xlate = held.valid && (held.ldst != 2'b00) && bus.vm_enable;
    for (int i = 0; i < N_BYP; i++) begin
      bv[i] = 1'($urandom_range(0, 1));
      ba[i*REG_ADDR_W +: REG_ADDR_W] = ($urandom_range(0, 2) != 0) ? held.dest : REG_ADDR_W'($urandom);
      bd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    bus.byp_valid = bv;
    bus.byp_addr  = ba;
    bus.byp_data  = bd;
    if (held.valid) begin
      e.data = held.data;
      found  = 1'b0;
      if (held.ldst == 2'b01) begin
        for (int i = 0; i < N_BYP; i++) begin
          if (!found && bv[i] && ba[i*REG_ADDR_W +: REG_ADDR_W] == held.dest) begin
            found  = 1'b1;
            e.data = bd[i*DATA_W +: DATA_W];
          end
        end
      end
      e.addr = held.alu;
      if (held_xlate) begin
        vpn = held.alu[DATA_W-1:PAGE_BITS];
        if (!model_hit(vpn)) refill_q.push_back(vpn);
        e.addr = {page_table(vpn), held.alu[PAGE_BITS-1:0]};
      end
      e.ldst = held.ldst;
      e.dest = held.dest;
      e.we   = held.we;
      e.bp   = held.bp;
      e.rob  = held.rob;
      sb_q.push_back(e);
    end
  endtask

  // One clock of stimulus, walker and flush activity; runs just after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
    bus.tlb_flush = 1'b0;
    if (cap_now) begin
      accept_held();
      make_op();
    end
    if (bus.refill_ack) begin
      bus.refill_ack = 1'b0;
      in_ep          = 1'b0;
    end else if (bus.refill_req) begin
      if (!in_ep) begin
        in_ep    = 1'b1;
        wait_cnt = 0;
        checks++;
        if (refill_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_refill: got vpn %0h expected no refill", bus.refill_vpn);
          pend_vpn = bus.refill_vpn;
        end else begin
          pend_vpn = refill_q.pop_front();
          if (bus.refill_vpn !== pend_vpn) begin
            errors++;
            $display("FAIL refill_vpn: got %0h expected %0h", bus.refill_vpn, pend_vpn);
          end
        end
        // Bypass sources retire while the op is stalled
        if ($urandom_range(0, 1) == 1) bus.byp_valid = '0;
      end
      wait_cnt++;
      if ($urandom_range(0, 2) == 0 || wait_cnt > 5) begin
        bus.refill_ack = 1'b1;
        bus.refill_ppn = page_table(pend_vpn);
        if ($urandom_range(0, 4) == 0) begin
          bus.tlb_flush = 1'b1;
          model_clear();
        end
        mvpn[mrr] = pend_vpn;
        mv[mrr]   = 1'b1;
        mrr       = (mrr + 1) % TLB_ENTRIES;
      end else if ($urandom_range(0, 6) == 0) begin
        bus.tlb_flush = 1'b1;
        model_clear();
      end
    end else if (!held_xlate && $urandom_range(0, 24) == 0) begin
      bus.tlb_flush = 1'b1;
      model_clear();
    end
    stall_run = bus.stall_out ? stall_run + 1 : 0;
    if (stall_run > 40) begin
      errors++;
      $display("FAIL stall_timeout: got %0d stalled cycles expected at most 40", stall_run);
      $fatal(1, "stage stalled indefinitely");
    end
    bus.enable_tlblookup = ($urandom_range(0, 4) != 0);
    cap_now = bus.enable_tlblookup && !bus.stall_out;
  endtask

  task automatic drain_pipe();
    drain = 1'b1;
    make_op();
    for (int k = 0; k < 80; k++) begin
      if (!held.valid && !bus.stall_out && !bus.refill_ack && sb_q.size() == 0) break;
      cycle();
    end
    drain = 1'b0;
  endtask

  // Monitor: every op handed to CACHE is matched against the oldest prediction
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (reset && bus.valid_out && bus.enable_tlblookup) begin
        a.addr = bus.tlblookup_result;
        a.data = bus.dataReg_output;
        a.ldst = bus.ldSt_enable_output;
        a.dest = bus.destReg_addr_output;
        a.we   = bus.we_output;
        a.bp   = bus.bp_output;
        a.rob  = bus.tail_rob_output;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got addr %0h data %0h expected no op", a.addr, a.data);
        end else begin
          e = sb_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL op_output: got addr %0h data %0h ldst %0d dest %0d we %0d bp %0d rob %0d expected addr %0h data %0h ldst %0d dest %0d we %0d bp %0d rob %0d",
                     a.addr, a.data, a.ldst, a.dest, a.we, a.bp, a.rob,
                     e.addr, e.data, e.ldst, e.dest, e.we, e.bp, e.rob);
          end
        end
      end
    end
  end

  initial begin : stimulus
    pres = '0; held = '0; held_xlate = 1'b0; cap_now = 1'b0;
    in_ep = 1'b0; drain = 1'b0; pend_vpn = '0; wait_cnt = 0; stall_run = 0; mrr = 0;
    model_clear();
    for (int j = 0; j < TLB_ENTRIES; j++) mvpn[j] = '0;
    vpn_pool[0] = 8'h34;
    for (int j = 1; j < 6; j++) vpn_pool[j] = VPN_W'($urandom);
    bus.enable_tlblookup = 1'b0; bus.valid_in = 1'b0; bus.alu_result = '0; bus.dataReg = '0;
    bus.ldSt_enable = '0; bus.destReg_addr_input = '0; bus.we_input = 1'b0; bus.bp_input = '0;
    bus.tail_rob_input = '0; bus.vm_enable = 1'b0; bus.tlb_flush = 1'b0; bus.byp_valid = '0;
    bus.byp_addr = '0; bus.byp_data = '0; bus.refill_ack = 1'b0; bus.refill_ppn = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset_stall_out", 32'(bus.stall_out), 32'd0);
    chk("reset_refill_req", 32'(bus.refill_req), 32'd0);
    chk("reset_result", 32'(bus.tlblookup_result), 32'd0);
    chk("reset_data", 32'(bus.dataReg_output), 32'd0);
    chk("reset_dest", 32'(bus.destReg_addr_output), 32'd0);
    reset = 1'b1;

    make_op();
    bus.enable_tlblookup = 1'b1;
    cap_now = 1'b1;

    // Translation bypassed: results are the raw ALU values
    repeat (300) cycle();
    drain_pipe();

    // Translation on: misses, refills, evictions, flushes, held-store bypass
    bus.vm_enable = 1'b1;
    repeat (1500) cycle();
    drain_pipe();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("refills_all_seen", 32'(refill_q.size()), 32'd0);

    // Reset in the middle of a refill wait
    bus.tlb_flush          = 1'b1;
    bus.valid_in           = 1'b1;
    bus.alu_result         = 16'h3456;
    bus.ldSt_enable        = 2'b10;
    bus.enable_tlblookup   = 1'b1;
    @(posedge clk);
    #1;
    bus.tlb_flush = 1'b0;
    bus.valid_in  = 1'b0;
    for (int k = 0; k < 5 && !bus.refill_req; k++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_refill_req", 32'(bus.refill_req), 32'd1);
    chk("wait_refill_vpn", 32'(bus.refill_vpn), 32'h34);
    reset = 1'b0;
    #1;
    chk("async_reset_refill_req", 32'(bus.refill_req), 32'd0);
    chk("async_reset_stall", 32'(bus.stall_out), 32'd0);
    chk("async_reset_valid", 32'(bus.valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
